// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage microRISC pipeline: load-use, redirect,
// multi-cycle EX and data-memory wait handling plus a saturating stall counter.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_W = 3,
   parameter int MUL_CYCLES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_use_rs1,
   input  logic                  id_use_rs2,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  ex_mem_read,
   input  logic                  ex_redirect,
   input  logic                  ex_multi,
   input  logic                  mem_busy,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  id_ex_stall,
   output logic                  ex_mem_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic                  mem_wb_flush,
   output logic                  busy,
   output logic [15:0]           stall_cycles
);

   localparam int CNT_W = $clog2(MUL_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MULTI    = 2'd1;
   localparam logic [1:0] ST_MEM_WAIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             multi_done_q, multi_done_d;
   logic [15:0]      stall_cycles_q, stall_cycles_d;
   logic             load_use;

   assign load_use = ex_mem_read && (ex_rd != '0) &&
                     ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                      (id_use_rs2 && (id_rs2 == ex_rd)));

   always_comb begin
      // NOTE: every output and next-state gets a default first so no latch is inferred.
      pc_stall     = 1'b0;
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      ex_mem_flush = 1'b0;
      mem_wb_flush = 1'b0;
      state_d      = state_q;
      count_d      = count_q;
      multi_done_d = multi_done_q;

      if (!rst) begin
         if (state_q == ST_MULTI) begin
            if (mem_busy) begin
               {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush} = '1;
               count_d = (count_q == '0) ? count_q : count_q - CNT_W'(1);
            end else if (count_q != '0) begin
               {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = '1;
               count_d = count_q - CNT_W'(1);
            end else begin
               multi_done_d = 1'b1;
               state_d      = ST_RUN;
            end
         end else begin
            state_d = ST_RUN;
            if (mem_busy) begin
               {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush} = '1;
               state_d = ST_MEM_WAIT;
            end else if (ex_multi && !multi_done_q) begin
               {pc_stall, if_id_stall, id_ex_stall, ex_mem_flush} = '1;
               count_d = CNT_LOAD;
               state_d = ST_MULTI;
            end else if (ex_redirect) begin
               {if_id_flush, id_ex_flush} = '1;
            end else if (load_use) begin
               {pc_stall, if_id_stall, id_ex_flush} = '1;
            end
            // Once EX moves on, a still-high ex_multi belongs to a new op.
            if (!ex_mem_stall) multi_done_d = 1'b0;
         end
      end
   end

   assign stall_cycles_d = (pc_stall && (stall_cycles_q != 16'hFFFF)) ?
                           stall_cycles_q + 16'd1 : stall_cycles_q;

   always_ff @(posedge clk or posedge rst) begin
      // NOTE: registered state is updated with non-blocking assignments only.
      if (rst) begin
         state_q        <= ST_RUN;
         count_q        <= '0;
         multi_done_q   <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         multi_done_q   <= multi_done_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign busy         = (state_q != ST_RUN);
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: an event-level model checked every
// cycle, plus literal expectations for each hazard scenario.
module tb_pipeline_hazard_ctrl;

   localparam int RW = 3;
   localparam int MC = 4;

   // Control vector order: pc, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, ex_mem_f, mem_wb_f
   localparam logic [7:0] FREEZE = 8'b1111_0001;
   localparam logic [7:0] MSTALL = 8'b1110_0010;
   localparam logic [7:0] REDIR  = 8'b0000_1100;
   localparam logic [7:0] LUSE   = 8'b1100_0100;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [RW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic          ex_mem_read = 1'b0, ex_redirect = 1'b0, ex_multi = 1'b0, mem_busy = 1'b0;
   logic          pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
   logic          if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic          busy;
   logic [15:0]   stall_cycles;
   logic [7:0]    ctrl8;

   int n_checks = 0;
   int n_err    = 0;

   // Model state: in a multi op, how many EX cycles it has used so far.
   bit m_multi, m_wait, m_done;
   int m_elapsed, m_stalls;

   pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .MUL_CYCLES(MC)) dut (
      .clk(clk), .rst(rst),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
      .ex_multi(ex_multi), .mem_busy(mem_busy),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
      .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .busy(busy), .stall_cycles(stall_cycles)
   );

   assign ctrl8 = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
                   if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [7:0] exp_ctrl();
      logic lu;
      lu = ex_mem_read && (ex_rd != 0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      if (rst) return 8'h00;
      if (mem_busy) return FREEZE;
      if (m_multi) return (m_elapsed < MC - 1) ? MSTALL : 8'h00;
      if (ex_multi && !m_done) return MSTALL;
      if (ex_redirect) return REDIR;
      if (lu) return LUSE;
      return 8'h00;
   endfunction

   always @(posedge clk or posedge rst) begin : model_upd
      logic [7:0] c;
      if (rst) begin
         m_multi   <= 1'b0;
         m_wait    <= 1'b0;
         m_done    <= 1'b0;
         m_elapsed <= 0;
         m_stalls  <= 0;
      end else begin
         c = exp_ctrl();
         if (c[7] && m_stalls < 65535) m_stalls <= m_stalls + 1;
         if (m_multi) begin
            if (mem_busy) m_elapsed <= (m_elapsed < MC - 1) ? m_elapsed + 1 : m_elapsed;
            else if (m_elapsed < MC - 1) m_elapsed <= m_elapsed + 1;
            else begin
               m_multi <= 1'b0;
               m_done  <= 1'b1;
            end
         end else begin
            m_wait <= mem_busy;
            if (!mem_busy) begin
               if (ex_multi && !m_done) begin
                  m_multi   <= 1'b1;
                  m_elapsed <= 1;
               end
               m_done <= 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("cycle_ctrl", {23'd0, busy, ctrl8}, {23'd0, (m_multi | m_wait), exp_ctrl()});
      check("cycle_stall_cycles", {16'd0, stall_cycles}, m_stalls);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle();
      {id_rs1, id_rs2, ex_rd} = '0;
      {id_use_rs1, id_use_rs2, ex_mem_read, ex_redirect, ex_multi, mem_busy} = '0;
   endtask

   initial begin
      #2;
      check("reset_ctrl", {23'd0, busy, ctrl8}, 0);
      check("reset_stall_cycles", stall_cycles, 0);
      tick();
      rst = 1'b0;
      settle();

      // Load-use through rs1: one bubble, then nothing.
      ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1;
      settle();
      check("lu_rs1_ctrl", ctrl8, LUSE);
      tick();
      idle();
      settle();
      check("lu_single_bubble", pc_stall, 0);
      check("lu_stall_count", stall_cycles, 1);
      tick();
      ex_mem_read = 1'b1; ex_rd = 3'd0; id_rs1 = 3'd0; id_use_rs1 = 1'b1;
      settle();
      check("lu_r0_no_stall", ctrl8, 0);
      tick();
      ex_rd = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b0;
      settle();
      check("lu_unused_no_stall", ctrl8, 0);
      tick();
      ex_rd = 3'd5; id_rs2 = 3'd5; id_use_rs2 = 1'b1;
      settle();
      check("lu_rs2_ctrl", ctrl8, LUSE);
      tick();
      idle();

      // Redirect together with load-use: flush only.
      ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3; id_use_rs1 = 1'b1; ex_redirect = 1'b1;
      settle();
      check("redir_lu_ctrl", ctrl8, REDIR);
      tick();
      idle();
      settle();
      check("redir_no_stall_count", stall_cycles, 2);
      tick();

      // ex_multi held 5 cycles: stall 3, release on the 4th, no re-trigger on the 5th.
      ex_multi = 1'b1;
      for (int i = 0; i < 5; i++) begin
         settle();
         check("multi_pc_stall", pc_stall, (i < 3));
         check("multi_busy", busy, (i >= 1 && i <= 3));
         tick();
      end
      idle();
      settle();
      check("multi_stall_count", stall_cycles, 5);
      tick();

      // mem_busy for 3 cycles from RUN.
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("mem_freeze_ctrl", ctrl8, FREEZE);
         check("mem_busy_flag", busy, (i >= 1));
         tick();
      end
      idle();
      settle();
      check("mem_after_ctrl", ctrl8, 0);
      check("mem_after_busy", busy, 1);
      check("mem_stall_count", stall_cycles, 8);
      tick();
      settle();
      check("mem_back_to_run", busy, 0);
      tick();

      // Multi op with redirect pending; mem_busy arrives once count has reached 0.
      ex_multi = 1'b1; ex_redirect = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check("mr_stall", ctrl8, MSTALL);
         tick();
      end
      mem_busy = 1'b1;
      for (int i = 0; i < 2; i++) begin
         settle();
         check("mr_freeze", ctrl8, FREEZE);
         check("mr_freeze_busy", busy, 1);
         tick();
      end
      mem_busy = 1'b0;
      settle();
      check("mr_release", ctrl8, 0);
      check("mr_release_busy", busy, 1);
      tick();
      settle();
      check("mr_redirect_after", ctrl8, REDIR);
      check("mr_redirect_busy", busy, 0);
      tick();
      idle();
      settle();
      check("mr_stall_count", stall_cycles, 13);
      tick();

      // Asynchronous reset in the middle of MULTI.
      ex_multi = 1'b1;
      settle();
      tick();
      settle();
      check("rst_pre_busy", busy, 1);
      rst = 1'b1;
      #1;
      check("rst_mid_ctrl", ctrl8, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_stall_count", stall_cycles, 0);
      tick();
      rst = 1'b0;
      idle();
      settle();
      check("rst_after_ctrl", {23'd0, busy, ctrl8}, 0);
      tick();
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage microRISC pipeline. Detects load-use hazards, branch/jump redirects, multi-cycle EX operations and data-memory wait states. Drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC hold. Keeps a saturating stall-cycle performance counter.

## Interface
- `REG_ADDR_W`, 3: register index width; R0 is hardwired zero.
- `MUL_CYCLES`, 4: total EX occupancy of a multi-cycle op; legal range ≥ 2.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `id_rs1`, `id_rs2`  in  REG_ADDR_W  source registers of the instruction in ID.
- `id_use_rs1`, `id_use_rs2`  in  1  ID instruction actually reads rs1 / rs2.
- `ex_rd`  in  REG_ADDR_W  destination register of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `ex_redirect`  in  1  taken branch or jump resolved in EX.
- `ex_multi`  in  1  EX holds a multi-cycle op; level signal.
- `mem_busy`  in  1  data memory not ready this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`  out  1  hold the PC or the named register.
- `if_id_flush`, `id_ex_flush`, `ex_mem_flush`, `mem_wb_flush`  out  1  load a bubble into the named register.
- `busy`  out  1  state ≠ RUN.
- `stall_cycles`  out  16  count of cycles with `pc_stall`=1; saturates at 0xFFFF.

## Operation
- Registered state: `state` (RUN, MULTI, MEM_WAIT), `count` ($clog2(MUL_CYCLES) bits), `multi_done`, `stall_cycles`.
- Control outputs are combinational from state and inputs, and are all 0 while `rst`=1.
- FREEZE set: `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall`, `mem_wb_flush` = 1. All other control outputs are 0.
- `load_use` = `ex_mem_read` & (`ex_rd`≠0) & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)).
- RUN and MEM_WAIT use identical decode, in this priority order:
  1. `mem_busy` → FREEZE; next state MEM_WAIT.
  2. `ex_multi` & !`multi_done` → `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_flush` = 1; `count` ← MUL_CYCLES-2; next state MULTI.
  3. `ex_redirect` → `if_id_flush` = `id_ex_flush` = 1; no stalls.
  4. `load_use` → `pc_stall` = `if_id_stall` = `id_ex_flush` = 1.
  5. Otherwise all control outputs 0.
  - Except under case 1, next state is RUN.
- MULTI:
  - `mem_busy` → FREEZE. `count` still decrements, saturating at 0. Stay in MULTI.
  - else `count`≠0 → stall pattern from RUN case 2; `count`--.
  - else (`count`==0) → all control outputs 0 (EX result advances); `multi_done` ← 1; next state RUN.
  - `ex_redirect`, `ex_multi` and `load_use` are ignored in MULTI.
- `multi_done` clears on the first RUN/MEM_WAIT cycle with `ex_mem_stall`=0. This prevents re-triggering on the same level-held `ex_multi`.
- `stall_cycles` increments on each rising edge where `pc_stall`=1, and holds at 0xFFFF.

## Timing
- Reset values (asynchronous): `state`=RUN, `count`=0, `multi_done`=0, `stall_cycles`=0, `busy`=0. All control outputs read 0 during reset.
- Reset mid-MULTI or mid-MEM_WAIT aborts immediately, with no further stall.
- Decode is zero-latency. The pipeline registers act on the same rising edge that follows the decode.
- Load-use costs exactly 1 bubble cycle. The next cycle the load is in MEM, so no hazard is re-detected.
- A multi-cycle op stalls fetch/decode for exactly MUL_CYCLES-1 cycles when `mem_busy` stays 0. Release occurs on the MUL_CYCLES-th cycle.
- A redirect costs 2 flushed slots and 0 stall cycles.
- Simultaneous events:
  - `mem_busy` beats everything.
  - A redirect with `load_use` → flush only.
  - A redirect with `ex_multi` → the multi-cycle op is served first. The redirect is decoded after release, since the signal level persists.

## Test plan
- Reset: enter MULTI, then assert `rst` mid-count → all outputs 0, `busy`=0, `stall_cycles`=0 without a clock edge.
- Load-use: `ex_mem_read`=1, `ex_rd`=3, `id_rs1`=3, `id_use_rs1`=1 → one cycle of `pc_stall`=`if_id_stall`=`id_ex_flush`=1. Repeat with `ex_rd`=0, or with `id_use_rs1`=0 → no stall.
- Redirect plus load-use in the same cycle → `if_id_flush`=`id_ex_flush`=1, `pc_stall`=0, `stall_cycles` unchanged.
- MUL_CYCLES=4, `ex_multi` held for 5 cycles → `pc_stall` high on cycles 0–2, low on cycle 3. No re-trigger on cycle 4. `stall_cycles`=3.
- `mem_busy` high for 3 cycles from RUN → FREEZE for 3 cycles, `busy`=1 on cycles 1–3, back to RUN, `stall_cycles`+=3.
- `mem_busy` raised while MULTI has `count`==0 → FREEZE, state stays MULTI. Release happens on the first cycle with `mem_busy`=0.
